import_search_sequencer: RTL and testbench
==========================================

Name: import_search_sequencer

Overview:
- Hardware name-resolution sequencer implementing the package import search order.
- Holds three tiers of lookup tables: a local-declaration table, an explicit-import table, and per-package export tables reached through wildcard imports.
- Serves one lookup at a time over a valid/ready handshake and scans one entry index per cycle.
- Reports where a name resolves (local, explicit, wildcard), or that it is not found, ambiguous, or a broken explicit import. Sits behind an elaboration-assist front end; configured through a simple write port.

Parameters:
NAME_W, 8, width of a name identifier
VAL_W, 32, width of the resolved value
NUM_PKG, 2, number of wildcard-imported packages (2..8)
LOCAL_DEPTH, 8, entries in the local table
EXPL_DEPTH, 4, entries in the explicit-import table
PKG_DEPTH, 8, entries per package table

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_clr  in  1  invalidate all entries in all tables
cfg_tier  in  2  0=local, 1=explicit, 2=package
cfg_pkg  in  3  package index (tier 2); target package (tier 1)
cfg_addr  in  clog2(max depth)  entry index
cfg_name  in  NAME_W  entry name
cfg_val  in  VAL_W  entry value (ignored for tier 1)
cfg_ready  out  1  configuration accepted this cycle
req_valid  in  1  lookup request
req_ready  out  1  lookup accepted
req_name  in  NAME_W  name to resolve
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumed
rsp_kind  out  3  0 NOT_FOUND, 1 LOCAL, 2 EXPLICIT, 3 WILDCARD, 4 AMBIGUOUS, 5 EXPL_BROKEN
rsp_val  out  VAL_W  resolved value (0 unless kind 1/2/3)
rsp_pkg  out  3  resolving package, or lowest ambiguous package
rsp_pkg2  out  3  second-lowest ambiguous package (0 otherwise)

Behaviour:
- Reset (async assert, sync deassert): state IDLE, all valid bits cleared, every output 0 except cfg_ready=1 and req_ready=1 on the first post-reset cycle. Reset mid-lookup aborts the lookup and drops any pending response.
- cfg_ready = (state==IDLE). cfg_we/cfg_clr outside IDLE are ignored. cfg_we in IDLE writes the entry and sets its valid bit. cfg_clr takes priority over cfg_we in the same cycle.
- req_ready = IDLE && !cfg_we && !cfg_clr. Configuration wins over a simultaneous request.
- Accept edge latches req_name and sets idx=0.
- State transitions:
  - SCAN_LOCAL: compare entry idx. On hit go to RESP with LOCAL (lowest index wins). At idx=LOCAL_DEPTH-1 with no hit, go to SCAN_EXPL.
  - SCAN_EXPL: on hit latch the target package and go to FETCH_EXPL. Otherwise, at the last entry, go to SCAN_WILD.
  - FETCH_EXPL: scan the target package table. On hit go to RESP with EXPLICIT, rsp_pkg = target. If no match in all PKG_DEPTH entries, go to RESP with EXPL_BROKEN. Wildcards are never consulted once an explicit import matches.
  - SCAN_WILD: compare index idx of all NUM_PKG tables in parallel and accumulate a per-package hit mask plus first-hit values. Always scans all PKG_DEPTH indices.
    - Zero hits: NOT_FOUND.
    - One hit: WILDCARD with that package.
    - Two or more hits: AMBIGUOUS with rsp_pkg/rsp_pkg2 set to the two lowest packages.
  - RESP: rsp_valid=1 with outputs held stable until rsp_ready. Return to IDLE on the edge where rsp_valid&&rsp_ready; outputs return to 0.
- Latency, with edge 1 = accept edge; rsp_valid is visible after the stated edge:
  - Local hit at index i: edge i+2.
  - Explicit hit at index j, package entry k: edge LOCAL_DEPTH+j+k+3.
  - Any wildcard outcome: edge LOCAL_DEPTH+EXPL_DEPTH+PKG_DEPTH+2.
- Invalid entries never match. The idx counter wraps to 0 on each state change. Table contents are not modified by lookups.

Test Plan:
- Local shadows wildcard: pkg0 {C=0x43,val 42}, local[3]={0x43,val 1}; lookup 0x43 -> LOCAL, val 1, rsp_valid after edge 5.
- Explicit priority: pkg0 C=42 at entry 2, pkg1 C=0, expl[0]={0x43,pkg0}; lookup 0x43 -> EXPLICIT, val 42, pkg 0, after edge 13; no AMBIGUOUS.
- Two wildcards, unique name: pkg0 {0x62 val 7}, pkg1 has no 0x62; lookup 0x62 -> WILDCARD, pkg 0, val 7, after edge 22.
- Ambiguity: both packages hold 0x43, no local/explicit; lookup -> AMBIGUOUS, rsp_pkg 0, rsp_pkg2 1, val 0. Separately, lookup 0x99 -> NOT_FOUND.
- Handshake/config: hold rsp_ready=0 for 5 cycles -> outputs stable. Assert cfg_we with req_valid in IDLE -> write applied, req_ready=0. cfg_we during a scan -> ignored. expl[0]={0x55,pkg1} with 0x55 absent from pkg1 -> EXPL_BROKEN.
- Reset mid-scan: drop rst_n during SCAN_WILD -> rsp_valid=0 immediately. After release, tables are empty and a lookup of 0x43 returns NOT_FOUND.

Source files
------------

// File: rtl/import_search_sequencer.sv
// Name-resolution sequencer for package import search order.
// Resolves one name at a time against three tiers of tables:
//   local declarations -> explicit imports -> wildcard-imported package exports.
// One table index is compared per cycle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_*           table write/clear port, accepted only while idle (cfg_ready)
//   req_valid/ready lookup request handshake, req_name is the name to resolve
//   rsp_valid/ready result handshake
//   rsp_kind        0 NOT_FOUND, 1 LOCAL, 2 EXPLICIT, 3 WILDCARD, 4 AMBIGUOUS, 5 EXPL_BROKEN
//   rsp_val         resolved value (0 unless LOCAL/EXPLICIT/WILDCARD)
//   rsp_pkg         resolving package, or lowest ambiguous package
//   rsp_pkg2        second-lowest ambiguous package
module import_search_sequencer #(
   parameter int unsigned NAME_W      = 8,
   parameter int unsigned VAL_W       = 32,
   parameter int unsigned NUM_PKG     = 2,
   parameter int unsigned LOCAL_DEPTH = 8,
   parameter int unsigned EXPL_DEPTH  = 4,
   parameter int unsigned PKG_DEPTH   = 8,
   localparam int unsigned MAX_DEPTH  = (LOCAL_DEPTH > EXPL_DEPTH) ?
                                        ((LOCAL_DEPTH > PKG_DEPTH) ? LOCAL_DEPTH : PKG_DEPTH) :
                                        ((EXPL_DEPTH > PKG_DEPTH) ? EXPL_DEPTH : PKG_DEPTH),
   localparam int unsigned ADDR_W     = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic              cfg_clr,
   input  logic [1:0]        cfg_tier,
   input  logic [2:0]        cfg_pkg,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [NAME_W-1:0] cfg_name,
   input  logic [VAL_W-1:0]  cfg_val,
   output logic              cfg_ready,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [NAME_W-1:0] req_name,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [2:0]        rsp_kind,
   output logic [VAL_W-1:0]  rsp_val,
   output logic [2:0]        rsp_pkg,
   output logic [2:0]        rsp_pkg2
);

   localparam int unsigned LOC_AW  = (LOCAL_DEPTH > 1) ? $clog2(LOCAL_DEPTH) : 1;
   localparam int unsigned EXPL_AW = (EXPL_DEPTH > 1) ? $clog2(EXPL_DEPTH) : 1;
   localparam int unsigned PD_AW   = (PKG_DEPTH > 1) ? $clog2(PKG_DEPTH) : 1;
   localparam int unsigned PKG_AW  = (NUM_PKG > 1) ? $clog2(NUM_PKG) : 1;
   localparam int unsigned IDX_W   = ADDR_W;

   localparam logic [2:0] K_NOT_FOUND = 3'd0;
   localparam logic [2:0] K_LOCAL     = 3'd1;
   localparam logic [2:0] K_EXPLICIT  = 3'd2;
   localparam logic [2:0] K_WILDCARD  = 3'd3;
   localparam logic [2:0] K_AMBIGUOUS = 3'd4;
   localparam logic [2:0] K_BROKEN    = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN_LOCAL, S_SCAN_EXPL, S_FETCH_EXPL, S_SCAN_WILD, S_WILD_DONE, S_RESP
   } state_t;

   // Tables: valid bits are reset, contents are not.
   logic [LOCAL_DEPTH-1:0]            loc_v;
   logic [NAME_W-1:0]                 loc_name [LOCAL_DEPTH];
   logic [VAL_W-1:0]                  loc_val  [LOCAL_DEPTH];
   logic [EXPL_DEPTH-1:0]             expl_v;
   logic [NAME_W-1:0]                 expl_name [EXPL_DEPTH];
   logic [2:0]                        expl_pkg  [EXPL_DEPTH];
   logic [NUM_PKG-1:0][PKG_DEPTH-1:0] pkg_v;
   logic [NAME_W-1:0]                 pkg_name [NUM_PKG][PKG_DEPTH];
   logic [VAL_W-1:0]                  pkg_val  [NUM_PKG][PKG_DEPTH];

   state_t                         state, state_d;
   logic [IDX_W-1:0]               idx, idx_d;
   logic [NAME_W-1:0]              name_q, name_d;
   logic [2:0]                     tgt_q, tgt_d;
   logic [NUM_PKG-1:0]             mask_q, mask_d;
   logic [NUM_PKG-1:0][VAL_W-1:0]  fval_q, fval_d;
   logic [2:0]                     kind_q, kind_d;
   logic [VAL_W-1:0]               val_q, val_d;
   logic [2:0]                     pkg_q, pkg_d;
   logic [2:0]                     pkg2_q, pkg2_d;

   logic                           cfg_ok, tbl_clr, we_loc, we_expl, we_pkg;
   logic                           loc_hit, expl_hit, fetch_hit, tgt_ok;
   logic [NUM_PKG-1:0]             wild_hit;
   logic [NUM_PKG-1:0][VAL_W-1:0]  wild_val;
   logic                           found1, found2;
   logic [2:0]                     p1, p2;
   logic [VAL_W-1:0]               v1;

   assign cfg_ready = (state == S_IDLE);
   assign req_ready = (state == S_IDLE) && !cfg_we && !cfg_clr;
   assign rsp_valid = (state == S_RESP);
   assign rsp_kind  = kind_q;
   assign rsp_val   = val_q;
   assign rsp_pkg   = pkg_q;
   assign rsp_pkg2  = pkg2_q;

   // Configuration decode; clear beats write, out-of-range addresses are dropped.
   assign tbl_clr = (state == S_IDLE) && cfg_clr;
   assign cfg_ok  = (state == S_IDLE) && cfg_we && !cfg_clr;
   assign we_loc  = cfg_ok && (cfg_tier == 2'd0) && (32'(cfg_addr) < LOCAL_DEPTH);
   assign we_expl = cfg_ok && (cfg_tier == 2'd1) && (32'(cfg_addr) < EXPL_DEPTH);
   assign we_pkg  = cfg_ok && (cfg_tier == 2'd2) && (32'(cfg_addr) < PKG_DEPTH) &&
                    (32'(cfg_pkg) < NUM_PKG);

   // Entry valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loc_v  <= '0;
         expl_v <= '0;
         pkg_v  <= '0;
      end else if (tbl_clr) begin
         loc_v  <= '0;
         expl_v <= '0;
         pkg_v  <= '0;
      end else begin
         if (we_loc)  loc_v[LOC_AW'(cfg_addr)]   <= 1'b1;
         if (we_expl) expl_v[EXPL_AW'(cfg_addr)] <= 1'b1;
         if (we_pkg)  pkg_v[PKG_AW'(cfg_pkg)][PD_AW'(cfg_addr)] <= 1'b1;
      end
   end

   // Entry contents.
   always_ff @(posedge clk) begin
      if (we_loc) begin
         loc_name[LOC_AW'(cfg_addr)] <= cfg_name;
         loc_val[LOC_AW'(cfg_addr)]  <= cfg_val;
      end
      if (we_expl) begin
         expl_name[EXPL_AW'(cfg_addr)] <= cfg_name;
         expl_pkg[EXPL_AW'(cfg_addr)]  <= cfg_pkg;
      end
      if (we_pkg) begin
         pkg_name[PKG_AW'(cfg_pkg)][PD_AW'(cfg_addr)] <= cfg_name;
         pkg_val[PKG_AW'(cfg_pkg)][PD_AW'(cfg_addr)]  <= cfg_val;
      end
   end

   // Per-cycle compare of entry idx in every tier.
   always_comb begin
      wild_hit = '0;
      wild_val = '0;
      tgt_ok   = (32'(tgt_q) < NUM_PKG);
      loc_hit  = loc_v[LOC_AW'(idx)] && (loc_name[LOC_AW'(idx)] == name_q);
      expl_hit = expl_v[EXPL_AW'(idx)] && (expl_name[EXPL_AW'(idx)] == name_q);
      fetch_hit = tgt_ok && pkg_v[PKG_AW'(tgt_q)][PD_AW'(idx)] &&
                  (pkg_name[PKG_AW'(tgt_q)][PD_AW'(idx)] == name_q);
      for (int p = 0; p < NUM_PKG; p++) begin
         wild_hit[p] = pkg_v[p][PD_AW'(idx)] && (pkg_name[p][PD_AW'(idx)] == name_q);
         wild_val[p] = pkg_val[p][PD_AW'(idx)];
      end
   end

   // Next state, scan bookkeeping and response payload.
   always_comb begin
      state_d = state;
      idx_d   = idx;
      name_d  = name_q;
      tgt_d   = tgt_q;
      mask_d  = mask_q;
      fval_d  = fval_q;
      kind_d  = kind_q;
      val_d   = val_q;
      pkg_d   = pkg_q;
      pkg2_d  = pkg2_q;
      found1  = 1'b0;
      found2  = 1'b0;
      p1      = '0;
      p2      = '0;
      v1      = '0;
      unique case (state)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               state_d = S_SCAN_LOCAL;
               idx_d   = '0;
               name_d  = req_name;
               mask_d  = '0;
            end
         end
         S_SCAN_LOCAL: begin
            if (loc_hit) begin
               state_d = S_RESP;
               idx_d   = '0;
               kind_d  = K_LOCAL;
               val_d   = loc_val[LOC_AW'(idx)];
               pkg_d   = '0;
               pkg2_d  = '0;
            end else if (idx == IDX_W'(LOCAL_DEPTH - 1)) begin
               state_d = S_SCAN_EXPL;
               idx_d   = '0;
            end else begin
               idx_d = idx + IDX_W'(1);
            end
         end
         S_SCAN_EXPL: begin
            if (expl_hit) begin
               state_d = S_FETCH_EXPL;
               idx_d   = '0;
               tgt_d   = expl_pkg[EXPL_AW'(idx)];
            end else if (idx == IDX_W'(EXPL_DEPTH - 1)) begin
               state_d = S_SCAN_WILD;
               idx_d   = '0;
            end else begin
               idx_d = idx + IDX_W'(1);
            end
         end
         S_FETCH_EXPL: begin
            // An explicit import match commits the search; wildcards are skipped.
            if (fetch_hit) begin
               state_d = S_RESP;
               idx_d   = '0;
               kind_d  = K_EXPLICIT;
               val_d   = pkg_val[PKG_AW'(tgt_q)][PD_AW'(idx)];
               pkg_d   = tgt_q;
               pkg2_d  = '0;
            end else if (idx == IDX_W'(PKG_DEPTH - 1)) begin
               state_d = S_RESP;
               idx_d   = '0;
               kind_d  = K_BROKEN;
               val_d   = '0;
               pkg_d   = '0;
               pkg2_d  = '0;
            end else begin
               idx_d = idx + IDX_W'(1);
            end
         end
         S_SCAN_WILD: begin
            // Keep only the lowest-index value found in each package.
            for (int p = 0; p < NUM_PKG; p++) begin
               if (wild_hit[p] && !mask_q[p]) fval_d[p] = wild_val[p];
            end
            mask_d = mask_q | wild_hit;
            if (idx == IDX_W'(PKG_DEPTH - 1)) begin
               state_d = S_WILD_DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx + IDX_W'(1);
            end
         end
         S_WILD_DONE: begin
            // Pick the two lowest packages with a hit.
            for (int p = 0; p < NUM_PKG; p++) begin
               if (mask_q[p]) begin
                  if (!found1) begin
                     found1 = 1'b1;
                     p1     = 3'(p);
                     v1     = fval_q[p];
                  end else if (!found2) begin
                     found2 = 1'b1;
                     p2     = 3'(p);
                  end
               end
            end
            state_d = S_RESP;
            if (!found1) begin
               kind_d = K_NOT_FOUND;
               val_d  = '0;
               pkg_d  = '0;
               pkg2_d = '0;
            end else if (!found2) begin
               kind_d = K_WILDCARD;
               val_d  = v1;
               pkg_d  = p1;
               pkg2_d = '0;
            end else begin
               kind_d = K_AMBIGUOUS;
               val_d  = '0;
               pkg_d  = p1;
               pkg2_d = p2;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
               kind_d  = '0;
               val_d   = '0;
               pkg_d   = '0;
               pkg2_d  = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         idx    <= '0;
         name_q <= '0;
         tgt_q  <= '0;
         mask_q <= '0;
         fval_q <= '0;
         kind_q <= '0;
         val_q  <= '0;
         pkg_q  <= '0;
         pkg2_q <= '0;
      end else begin
         state  <= state_d;
         idx    <= idx_d;
         name_q <= name_d;
         tgt_q  <= tgt_d;
         mask_q <= mask_d;
         fval_q <= fval_d;
         kind_q <= kind_d;
         val_q  <= val_d;
         pkg_q  <= pkg_d;
         pkg2_q <= pkg2_d;
      end
   end

endmodule

// File: tb/tb_import_search_sequencer.sv
// Self-checking bench for import_search_sequencer: directed scenarios plus
// randomized table contents, with a search-order reference model feeding a
// scoreboard that a separate response monitor drains.
module tb_import_search_sequencer;

   localparam int unsigned NAME_W  = 8;
   localparam int unsigned VAL_W   = 32;
   localparam int unsigned NUM_PKG = 2;
   localparam int unsigned LD      = 8;
   localparam int unsigned ED      = 4;
   localparam int unsigned PD      = 8;
   localparam int unsigned TO      = 200;

   localparam logic [2:0] K_NF    = 3'd0;
   localparam logic [2:0] K_LOCAL = 3'd1;
   localparam logic [2:0] K_EXPL  = 3'd2;
   localparam logic [2:0] K_WILD  = 3'd3;
   localparam logic [2:0] K_AMBIG = 3'd4;
   localparam logic [2:0] K_BROKE = 3'd5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              cfg_we = 1'b0;
   logic              cfg_clr = 1'b0;
   logic [1:0]        cfg_tier = '0;
   logic [2:0]        cfg_pkg = '0;
   logic [2:0]        cfg_addr = '0;
   logic [NAME_W-1:0] cfg_name = '0;
   logic [VAL_W-1:0]  cfg_val = '0;
   logic              cfg_ready;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [NAME_W-1:0] req_name = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [2:0]        rsp_kind;
   logic [VAL_W-1:0]  rsp_val;
   logic [2:0]        rsp_pkg;
   logic [2:0]        rsp_pkg2;

   import_search_sequencer #(
      .NAME_W(NAME_W), .VAL_W(VAL_W), .NUM_PKG(NUM_PKG),
      .LOCAL_DEPTH(LD), .EXPL_DEPTH(ED), .PKG_DEPTH(PD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_tier(cfg_tier), .cfg_pkg(cfg_pkg),
      .cfg_addr(cfg_addr), .cfg_name(cfg_name), .cfg_val(cfg_val), .cfg_ready(cfg_ready),
      .req_valid(req_valid), .req_ready(req_ready), .req_name(req_name),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_kind(rsp_kind),
      .rsp_val(rsp_val), .rsp_pkg(rsp_pkg), .rsp_pkg2(rsp_pkg2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  kind;
      logic [31:0] val;
      logic [2:0]  pkg;
      logic [2:0]  pkg2;
      int unsigned due;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned edge_n = 0;
   bit          force_hold = 1'b0;
   bit          mon_active = 1'b0;

   // Reference tables.
   logic        m_lv [LD];
   logic [7:0]  m_ln [LD];
   logic [31:0] m_lval [LD];
   logic        m_ev [ED];
   logic [7:0]  m_en [ED];
   logic [2:0]  m_ep [ED];
   logic        m_pv [NUM_PKG][PD];
   logic [7:0]  m_pn [NUM_PKG][PD];
   logic [31:0] m_pval [NUM_PKG][PD];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < LD; i++) m_lv[i] = 1'b0;
      for (int i = 0; i < ED; i++) m_ev[i] = 1'b0;
      for (int p = 0; p < NUM_PKG; p++)
         for (int k = 0; k < PD; k++) m_pv[p][k] = 1'b0;
   endtask

   // Search order: local, then explicit import (commits), then all wildcard packages.
   function automatic exp_t model(input logic [7:0] nm, input int unsigned acc);
      exp_t        e;
      int unsigned nhit;
      logic [2:0]  hp [2];
      logic [31:0] hv [2];
      int          tp;
      e.kind = K_NF; e.val = '0; e.pkg = '0; e.pkg2 = '0;
      e.due  = acc + LD + ED + PD + 1;
      for (int i = 0; i < LD; i++)
         if (m_lv[i] && m_ln[i] == nm) begin
            e.kind = K_LOCAL; e.val = m_lval[i]; e.due = acc + 32'(i) + 1;
            return e;
         end
      for (int j = 0; j < ED; j++)
         if (m_ev[j] && m_en[j] == nm) begin
            tp = int'(m_ep[j]);
            for (int k = 0; k < PD; k++)
               if (m_pv[tp][k] && m_pn[tp][k] == nm) begin
                  e.kind = K_EXPL; e.val = m_pval[tp][k]; e.pkg = m_ep[j];
                  e.due  = acc + LD + 32'(j) + 32'(k) + 2;
                  return e;
               end
            e.kind = K_BROKE; e.due = acc + LD + 32'(j) + PD + 1;
            return e;
         end
      nhit = 0;
      hp[0] = '0; hp[1] = '0; hv[0] = '0; hv[1] = '0;
      for (int p = 0; p < NUM_PKG; p++)
         for (int k = 0; k < PD; k++)
            if (m_pv[p][k] && m_pn[p][k] == nm) begin
               if (nhit < 2) begin hp[nhit] = 3'(p); hv[nhit] = m_pval[p][k]; end
               nhit++;
               break;
            end
      if (nhit == 1) begin
         e.kind = K_WILD; e.val = hv[0]; e.pkg = hp[0];
      end else if (nhit >= 2) begin
         e.kind = K_AMBIG; e.pkg = hp[0]; e.pkg2 = hp[1];
      end
      return e;
   endfunction

   initial forever begin
      @(posedge clk);
      edge_n++;
   end

   // Response monitor: pops on the first cycle of each response, then checks hold stability.
   initial begin
      exp_t       e;
      int         hold_n;
      logic [44:0] saved;
      hold_n = 0;
      saved  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_active = 1'b0;
            rsp_ready  = 1'b0;
         end else if (rsp_valid) begin
            if (!mon_active) begin
               mon_active = 1'b1;
               if (sbq.size() == 0) begin
                  chk("unexpected_rsp", 64'(rsp_kind), 64'(3'd7));
               end else begin
                  e = sbq.pop_front();
                  chk("rsp_kind", 64'(rsp_kind), 64'(e.kind));
                  chk("rsp_val", 64'(rsp_val), 64'(e.val));
                  chk("rsp_pkg", 64'(rsp_pkg), 64'(e.pkg));
                  chk("rsp_pkg2", 64'(rsp_pkg2), 64'(e.pkg2));
                  chk("rsp_latency_edge", 64'(edge_n), 64'(e.due));
               end
               saved  = {rsp_kind, rsp_val, rsp_pkg, rsp_pkg2, rsp_kind};
               hold_n = force_hold ? 5 : int'($urandom_range(0, 2));
            end else begin
               chk("rsp_hold_stable", 64'({rsp_kind, rsp_val, rsp_pkg, rsp_pkg2, rsp_kind}),
                   64'(saved));
            end
            if (hold_n > 0) begin
               rsp_ready = 1'b0;
               hold_n--;
            end else begin
               rsp_ready = 1'b1;
            end
         end else begin
            if (mon_active) begin
               mon_active = 1'b0;
               chk("rsp_cleared", 64'({rsp_kind, rsp_val, rsp_pkg, rsp_pkg2}), 64'(0));
            end
            rsp_ready = 1'b0;
         end
      end
   end

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         if (cfg_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 64'(0), 64'(1));
   endtask

   task automatic cfg_write(input int tier, input int pkg, input int addr,
                            input logic [7:0] nm, input logic [31:0] v);
      bit ok;
      wait_idle(ok);
      if (!ok) return;
      cfg_we = 1'b1; cfg_tier = 2'(tier); cfg_pkg = 3'(pkg); cfg_addr = 3'(addr);
      cfg_name = nm; cfg_val = v;
      @(negedge clk);
      cfg_we = 1'b0;
      case (tier)
         0: begin m_lv[addr] = 1'b1; m_ln[addr] = nm; m_lval[addr] = v; end
         1: begin m_ev[addr] = 1'b1; m_en[addr] = nm; m_ep[addr] = 3'(pkg); end
         default: begin m_pv[pkg][addr] = 1'b1; m_pn[pkg][addr] = nm; m_pval[pkg][addr] = v; end
      endcase
   endtask

   // Clear all tables; optionally with a competing write that must lose.
   task automatic clr_all(input bit also_we);
      bit ok;
      wait_idle(ok);
      if (!ok) return;
      cfg_clr = 1'b1; cfg_we = also_we; cfg_tier = 2'd0; cfg_addr = 3'd0;
      cfg_name = 8'h40; cfg_val = 32'hdead_beef;
      @(negedge clk);
      cfg_clr = 1'b0; cfg_we = 1'b0;
      model_clear();
   endtask

   // Issue a lookup; returns at the negedge after the accept edge.
   task automatic lookup(input logic [7:0] nm);
      bit ok;
      wait_idle(ok);
      if (!ok) return;
      req_valid = 1'b1;
      req_name  = nm;
      sbq.push_back(model(nm, edge_n + 1));
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      model_clear();
      #1 rst_n = 1'b0;
      #2;
      chk("reset_cfg_ready", 64'(cfg_ready), 64'(1));
      chk("reset_req_ready", 64'(req_ready), 64'(1));
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_rsp_fields", 64'({rsp_kind, rsp_val, rsp_pkg, rsp_pkg2}), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_ready", 64'({cfg_ready, req_ready}), 64'(2'b11));

      // Local shadows wildcard.
      cfg_write(2, 0, 0, 8'h43, 32'd42);
      cfg_write(0, 0, 3, 8'h43, 32'd1);
      lookup(8'h43);

      // Explicit import beats a would-be ambiguity.
      clr_all(1'b0);
      cfg_write(2, 0, 2, 8'h43, 32'd42);
      cfg_write(2, 1, 0, 8'h43, 32'd0);
      cfg_write(1, 0, 0, 8'h43, 32'd0);
      lookup(8'h43);

      // Unique wildcard.
      clr_all(1'b0);
      cfg_write(2, 0, 1, 8'h62, 32'd7);
      cfg_write(2, 1, 4, 8'h63, 32'd8);
      lookup(8'h62);

      // Ambiguity and not-found, with a long rsp_ready stall on the first.
      clr_all(1'b0);
      cfg_write(2, 0, 4, 8'h43, 32'd11);
      cfg_write(2, 1, 2, 8'h43, 32'd22);
      force_hold = 1'b1;
      lookup(8'h43);
      wait_idle(ok);
      force_hold = 1'b0;
      lookup(8'h99);

      // Config and request together: config wins, request not accepted.
      wait_idle(ok);
      cfg_we = 1'b1; cfg_tier = 2'd0; cfg_pkg = 3'd0; cfg_addr = 3'd5;
      cfg_name = 8'h66; cfg_val = 32'h1234;
      req_valid = 1'b1; req_name = 8'h66;
      #1 chk("req_ready_under_cfg", 64'(req_ready), 64'(0));
      @(negedge clk);
      cfg_we = 1'b0; req_valid = 1'b0;
      m_lv[5] = 1'b1; m_ln[5] = 8'h66; m_lval[5] = 32'h1234;
      chk("cfg_wins_stays_idle", 64'(cfg_ready), 64'(1));
      lookup(8'h66);

      // Write attempted mid-scan must be ignored.
      cfg_we = 1'b1; cfg_tier = 2'd0; cfg_addr = 3'd1; cfg_name = 8'h67; cfg_val = 32'd9;
      #1 chk("cfg_ready_busy", 64'(cfg_ready), 64'(0));
      @(negedge clk);
      cfg_we = 1'b0;
      lookup(8'h67);

      // Explicit import to a package lacking the name.
      clr_all(1'b0);
      cfg_write(1, 1, 0, 8'h55, 32'd0);
      cfg_write(2, 0, 0, 8'h55, 32'd3);
      lookup(8'h55);

      // Randomized tables over a small alphabet so tiers collide often.
      for (int r = 0; r < 4; r++) begin
         clr_all(1'($urandom_range(0, 1)));
         for (int n = 0; n < 14; n++) begin
            int t;
            t = int'($urandom_range(0, 2));
            cfg_write(t, int'($urandom_range(0, NUM_PKG - 1)),
                      (t == 1) ? int'($urandom_range(0, ED - 1)) : int'($urandom_range(0, PD - 1)),
                      8'(8'h40 + $urandom_range(0, 7)), $urandom);
         end
         for (int n = 0; n < 8; n++) lookup(8'(8'h40 + $urandom_range(0, 8)));
      end

      // Reset in the middle of the wildcard scan.
      clr_all(1'b0);
      cfg_write(2, 0, 3, 8'h43, 32'd5);
      cfg_write(2, 1, 6, 8'h43, 32'd6);
      lookup(8'h43);
      repeat (15) @(negedge clk);
      chk("busy_before_reset", 64'(cfg_ready), 64'(0));
      #2 rst_n = 1'b0;
      #1;
      chk("midscan_reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("midscan_reset_ready", 64'({cfg_ready, req_ready}), 64'(2'b11));
      sbq.delete();
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lookup(8'h43);

      wait_idle(ok);
      for (int i = 0; i < TO && (sbq.size() != 0 || mon_active); i++) @(negedge clk);
      chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
